// File: rtl/alu_seq.sv
// Wide add/sub/and/or/xor: one limb per cycle through a single ALU, LS limb first; Done Limbs+1 cycles after accept.
// Single requester; Start ignored unless Ready. Define ALU_SEQ_CARRYIN_EN to add a CIn carry/borrow-in port.
module alu #(
  parameter int DataWidth = 8
) (
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic [3:0]           func_op,
  input  logic                 cin,
  output logic [DataWidth-1:0] y,
  output logic [3:0]           flags
);
  logic [DataWidth:0] sum;
  logic               c;
  logic               v;

  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (func_op)
      4'b0000: begin
        sum = {1'b0, a} + {1'b0, b} + {{DataWidth{1'b0}}, cin};
        y   = sum[DataWidth-1:0];
        c   = sum[DataWidth];
        v   = (a[DataWidth-1] == b[DataWidth-1]) && (y[DataWidth-1] != a[DataWidth-1]);
      end
      4'b0001: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{DataWidth{1'b0}}, cin};
        y   = sum[DataWidth-1:0];
        c   = sum[DataWidth];
        v   = (a[DataWidth-1] != b[DataWidth-1]) && (y[DataWidth-1] != a[DataWidth-1]);
      end
      4'b0010: y = a & b;
      4'b0011: y = a | b;
      4'b0100: y = a ^ b;
      default: y = '0;
    endcase
  end

  assign flags = {v, y[DataWidth-1], c, (y == '0)};
endmodule

module alu_seq #(
  parameter int DataWidth = 8,
  parameter int Limbs     = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
`ifdef ALU_SEQ_CARRYIN_EN
  input  logic                       CIn,
`endif
  input  logic [3:0]                 Op,
  input  logic [DataWidth*Limbs-1:0] A,
  input  logic [DataWidth*Limbs-1:0] B,
  output logic                       Ready,
  output logic                       Done,
  output logic [DataWidth*Limbs-1:0] Y,
  output logic [3:0]                 Flags
);
  localparam int IW = (Limbs > 1) ? $clog2(Limbs) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(Limbs - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;

  logic [1:0]                          state;
  logic [IW-1:0]                       idx;
  logic                                carry;
  logic                                zacc;
  logic [3:0]                          op_q;
  logic [Limbs-1:0][DataWidth-1:0]     a_q;
  logic [Limbs-1:0][DataWidth-1:0]     b_q;
  logic [Limbs-1:0][DataWidth-1:0]     y_q;
  logic [3:0]                          flags_q;

  logic                 init_carry;
  logic                 is_arith;
  logic [DataWidth-1:0] alu_b;
  logic [3:0]           alu_op;
  logic [DataWidth-1:0] alu_y;
  logic [3:0]           alu_f;

`ifdef ALU_SEQ_CARRYIN_EN
  assign init_carry = ((Op == OpAdd) || (Op == OpSub)) ? CIn : 1'b0;
`else
  assign init_carry = (Op == OpSub);
`endif

  // Subtract runs through the adder as A + ~B + carry-in.
  assign is_arith = (op_q == OpAdd) || (op_q == OpSub);
  assign alu_b    = (op_q == OpSub) ? ~b_q[idx] : b_q[idx];
  assign alu_op   = is_arith ? OpAdd : op_q;

  alu #(.DataWidth(DataWidth)) u_alu (
    .a       (a_q[idx]),
    .b       (alu_b),
    .func_op (alu_op),
    .cin     (carry),
    .y       (alu_y),
    .flags   (alu_f)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      zacc    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= Op;
            idx   <= '0;
            carry <= init_carry;
            zacc  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          y_q[idx] <= alu_y;
          carry    <= alu_f[1];
          zacc     <= zacc & alu_f[0];
          if (idx == LastIdx) begin
            flags_q <= {is_arith & alu_f[3], alu_f[2], is_arith & alu_f[1], zacc & alu_f[0]};
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Ready = (state == IDLE);
  assign Done  = (state == DONE);
  assign Y     = y_q;
  assign Flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (8-bit limbs, 4 limbs); CIn vectors only when ALU_SEQ_CARRYIN_EN is defined.
module tb_alu_seq;
  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        CIn;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Ready;
  logic        Done;
  logic [31:0] Y;
  logic [3:0]  Flags;

  typedef struct {
    string       name;
    logic [31:0] y;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_seq #(.DataWidth(8), .Limbs(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
`ifdef ALU_SEQ_CARRYIN_EN
    .CIn   (CIn),
`endif
    .Op    (Op),
    .A     (A),
    .B     (B),
    .Ready (Ready),
    .Done  (Done),
    .Y     (Y),
    .Flags (Flags)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: Done=1 with nothing pending, Y=0x%0h Flags=0x%0h", Y, Flags);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_y"}, Y, e.y);
        check({e.name, "_flags"}, 32'(Flags), 32'(e.f));
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic [31:0] ey,
                        input logic [3:0] ef);
    int n;
    n = 0;
    while (!Ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_ready_before"}, 32'(Ready), 32'd1);
    Op    = op;
    A     = a;
    B     = b;
    CIn   = cin;
    Start = 1'b1;
    sb.push_back('{name, ey, ef});
    @(posedge Clk);
    #1;
    // Scramble inputs after the accepting edge; they must not matter.
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    Op    = 4'($urandom);
    CIn   = ~cin;
    check({name, "_ready_busy"}, 32'(Ready), 32'd0);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Done && n < 20);
    check({name, "_latency"}, 32'(n), 32'd5);
    check({name, "_ready_in_done"}, 32'(Ready), 32'd0);
    @(negedge Clk);
    check({name, "_ready_after"}, 32'(Ready), 32'd1);
    check({name, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    CIn   = 1'b0;
    Op    = '0;
    A     = '0;
    B     = '0;
    #2;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_y", Y, 32'h0);
    check("rst_flags", 32'(Flags), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // Flags are {V,N,C,Z}
    run_op("add_ff_1",    4'b0000, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 4'b0000);
    run_op("add_wrap",    4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0011);
    run_op("add_ovf",     4'b0000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1100);
    run_op("sub_5_7",     4'b0001, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 4'b0100);
    run_op("sub_7_5",     4'b0001, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 4'b0010);
    run_op("xor_same",    4'b0100, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 4'b0001);
    run_op("and_mix",     4'b0010, 32'hF0F0FFFF, 32'h0FF0F00F, 1'b1, 32'h00F0F00F, 4'b0000);
    run_op("or_msb",      4'b0011, 32'h80000000, 32'h00000001, 1'b1, 32'h80000001, 4'b0100);
    run_op("op_invalid",  4'b1111, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h00000000, 4'b0001);

    // Reset mid-RUN: no Done for the aborted op, then a clean op.
    while (!Ready) @(negedge Clk);
    Op    = 4'b0000;
    A     = 32'h01010101;
    B     = 32'h01010101;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    Start = 1'b1;
    A     = 32'hDEADBEEF;
    B     = 32'h11111111;
    Op    = 4'b0001;
    @(posedge Clk);
    #1;
    check("abort_ready_busy", 32'(Ready), 32'd0);
    Start = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("abort_ready", 32'(Ready), 32'd1);
    check("abort_y", Y, 32'h0);
    check("abort_flags", 32'(Flags), 32'h0);
    check("abort_done", 32'(Done), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (8) @(negedge Clk);
    run_op("add_after_rst", 4'b0000, 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 4'b0000);

`ifdef ALU_SEQ_CARRYIN_EN
    run_op("adc_cin1",    4'b0000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0011);
    run_op("sbc_cin0",    4'b0001, 32'h00000005, 32'h00000005, 1'b0, 32'hFFFFFFFF, 4'b0100);
`endif

    repeat (4) @(negedge Clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
